// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central hazard controller for a 5-stage RV32 pipeline.
//            - ID-stage forwarding enables/selects (EX > MEM > WB priority)
//            - load-use bubble insertion
//            - branch/jump redirect flushes
//            - MUL/DIV sequencing with front-end freeze and timeout release
// Ports    : clk, rst_n (async, active low)
//            ID sources : rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i
//            Writers    : wr_ex_i/rf_we_ex_i/wd_sel_ex_i, wr_mem_i/rf_we_mem_i,
//                         wr_wb_i/rf_we_wb_i
//            Control in : redirect_ex_i, md_req_ex_i, md_done_i
//            Control out: stall_pc_o, stall_if_id_o, flush_if_id_o,
//                         flush_id_ex_o, stall_id_ex_o, bubble_ex_mem_o,
//                         md_start_o
//            Forwarding : fwd_rD1e_o/fwd_rD1_sel_o, fwd_rD2e_o/fwd_rD2_sel_o
//            Status     : md_timeout_o (sticky), stall_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int         MD_TIMEOUT  = 64,
  parameter logic [1:0] WD_SEL_LOAD = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_id_i,
  input  logic [4:0]  rs2_id_i,
  input  logic        rs1_used_id_i,
  input  logic        rs2_used_id_i,
  input  logic [4:0]  wr_ex_i,
  input  logic        rf_we_ex_i,
  input  logic [1:0]  wd_sel_ex_i,
  input  logic [4:0]  wr_mem_i,
  input  logic        rf_we_mem_i,
  input  logic [4:0]  wr_wb_i,
  input  logic        rf_we_wb_i,
  input  logic        redirect_ex_i,
  input  logic        md_req_ex_i,
  input  logic        md_done_i,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        stall_id_ex_o,
  output logic        bubble_ex_mem_o,
  output logic        md_start_o,
  output logic        fwd_rD1e_o,
  output logic [1:0]  fwd_rD1_sel_o,
  output logic        fwd_rD2e_o,
  output logic [1:0]  fwd_rD2_sel_o,
  output logic        md_timeout_o,
  output logic [31:0] stall_cnt_o
);

  localparam int         CW         = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(MD_TIMEOUT - 1);

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam logic [1:0] SEL_EX  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          md_start_q, md_start_d;
  logic          md_timeout_q, md_timeout_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          w_lu;
  logic          w_ex_fwd_ok;

  // A load's data is not available in EX, so it is excluded from EX matches.
  assign w_ex_fwd_ok = rf_we_ex_i && (wd_sel_ex_i != WD_SEL_LOAD);

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_rD1e_o    = 1'b0;
    fwd_rD1_sel_o = SEL_EX;
    if (rs1_used_id_i && (rs1_id_i != 5'd0)) begin
      if (w_ex_fwd_ok && (wr_ex_i == rs1_id_i)) begin
        fwd_rD1e_o = 1'b1; fwd_rD1_sel_o = SEL_EX;
      end else if (rf_we_mem_i && (wr_mem_i == rs1_id_i)) begin
        fwd_rD1e_o = 1'b1; fwd_rD1_sel_o = SEL_MEM;
      end else if (rf_we_wb_i && (wr_wb_i == rs1_id_i)) begin
        fwd_rD1e_o = 1'b1; fwd_rD1_sel_o = SEL_WB;
      end
    end
  end

  always_comb begin
    fwd_rD2e_o    = 1'b0;
    fwd_rD2_sel_o = SEL_EX;
    if (rs2_used_id_i && (rs2_id_i != 5'd0)) begin
      if (w_ex_fwd_ok && (wr_ex_i == rs2_id_i)) begin
        fwd_rD2e_o = 1'b1; fwd_rD2_sel_o = SEL_EX;
      end else if (rf_we_mem_i && (wr_mem_i == rs2_id_i)) begin
        fwd_rD2e_o = 1'b1; fwd_rD2_sel_o = SEL_MEM;
      end else if (rf_we_wb_i && (wr_wb_i == rs2_id_i)) begin
        fwd_rD2e_o = 1'b1; fwd_rD2_sel_o = SEL_WB;
      end
    end
  end

  // Load-use: the load's data only exists after MEM, so ID must wait a cycle.
  assign w_lu = rf_we_ex_i && (wd_sel_ex_i == WD_SEL_LOAD) && (wr_ex_i != 5'd0) &&
                ((rs1_used_id_i && (rs1_id_i == wr_ex_i)) ||
                 (rs2_used_id_i && (rs2_id_i == wr_ex_i)));

  // --------------------------------------------------------------------------
  // MUL/DIV FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MD_IDLE;
      md_cnt_q     <= '0;
      md_start_q   <= 1'b0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_start_q   <= md_start_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // MUL/DIV FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_start_d   = 1'b0;
    md_timeout_d = md_timeout_q;
    case (state_q)
      MD_IDLE: begin
        if (md_req_ex_i) begin
          state_d    = MD_BUSY;
          md_cnt_d   = '0;
          // Registered so the start pulse is a clean flop output in the
          // first BUSY cycle.
          md_start_d = 1'b1;
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q + 1'b1;
        if (md_done_i) begin
          state_d = MD_DONE;
        end else if (md_cnt_q == C_CNT_LAST) begin
          state_d      = MD_DONE;
          md_timeout_d = 1'b1;
        end
      end
      // DONE never samples md_req_ex_i: the same MUL/DIV is still in EX.
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // MUL/DIV FSM: outputs (stall/flush)
  // --------------------------------------------------------------------------
  always_comb begin
    stall_pc_o      = 1'b0;
    stall_if_id_o   = 1'b0;
    flush_if_id_o   = 1'b0;
    flush_id_ex_o   = 1'b0;
    stall_id_ex_o   = 1'b0;
    bubble_ex_mem_o = 1'b0;
    if (state_q == MD_BUSY) begin
      // Freeze the front end and keep EX/MEM empty; lu/redirect are moot.
      stall_pc_o      = 1'b1;
      stall_if_id_o   = 1'b1;
      stall_id_ex_o   = 1'b1;
      bubble_ex_mem_o = 1'b1;
    end else if (redirect_ex_i) begin
      // The stalled ID instruction is on the wrong path anyway.
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (w_lu) begin
      stall_pc_o    = 1'b1;
      stall_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

  assign stall_cnt_d  = stall_pc_o ? (stall_cnt_q + 32'd1) : stall_cnt_q;
  assign md_start_o   = md_start_q;
  assign md_timeout_o = md_timeout_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_id, rs2_id, wr_ex, wr_mem, wr_wb;
  logic        rs1_used, rs2_used, rf_we_ex, rf_we_mem, rf_we_wb;
  logic [1:0]  wd_sel_ex;
  logic        redirect_ex, md_req_ex, md_done;
  logic        stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_id_ex;
  logic        bubble_ex_mem, md_start, fwd_rD1e, fwd_rD2e, md_timeout;
  logic [1:0]  fwd_rD1_sel, fwd_rD2_sel;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_TIMEOUT(64), .WD_SEL_LOAD(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id_i(rs1_id), .rs2_id_i(rs2_id),
    .rs1_used_id_i(rs1_used), .rs2_used_id_i(rs2_used),
    .wr_ex_i(wr_ex), .rf_we_ex_i(rf_we_ex), .wd_sel_ex_i(wd_sel_ex),
    .wr_mem_i(wr_mem), .rf_we_mem_i(rf_we_mem),
    .wr_wb_i(wr_wb), .rf_we_wb_i(rf_we_wb),
    .redirect_ex_i(redirect_ex), .md_req_ex_i(md_req_ex), .md_done_i(md_done),
    .stall_pc_o(stall_pc), .stall_if_id_o(stall_if_id),
    .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
    .stall_id_ex_o(stall_id_ex), .bubble_ex_mem_o(bubble_ex_mem),
    .md_start_o(md_start),
    .fwd_rD1e_o(fwd_rD1e), .fwd_rD1_sel_o(fwd_rD1_sel),
    .fwd_rD2e_o(fwd_rD2e), .fwd_rD2_sel_o(fwd_rD2_sel),
    .md_timeout_o(md_timeout), .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clr_inputs();
    rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
    wr_ex = 0; rf_we_ex = 0; wd_sel_ex = 2'b00;
    wr_mem = 0; rf_we_mem = 0; wr_wb = 0; rf_we_wb = 0;
    redirect_ex = 0; md_req_ex = 0; md_done = 0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin : main
    int nstall;
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall_pc",  32'(stall_pc), 32'd0);
    check("rst_md_start",  32'(md_start), 32'd0);
    check("rst_timeout",   32'(md_timeout), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // ---- load-use: lw x5 in EX, ID reads rs1=5 ----
    wr_ex = 5; rf_we_ex = 1; wd_sel_ex = 2'b01; rs1_id = 5; rs1_used = 1;
    @(negedge clk);
    check("lu_stall_pc",    32'(stall_pc), 32'd1);
    check("lu_stall_if_id", 32'(stall_if_id), 32'd1);
    check("lu_flush_id_ex", 32'(flush_id_ex), 32'd1);
    check("lu_no_fwd",      32'(fwd_rD1e), 32'd0);
    next_cycle();
    // load now in MEM, bubble in EX
    rf_we_ex = 0; wd_sel_ex = 2'b00; wr_ex = 0; wr_mem = 5; rf_we_mem = 1;
    @(negedge clk);
    check("lu2_stall_pc",  32'(stall_pc), 32'd0);
    check("lu2_fwd_en",    32'(fwd_rD1e), 32'd1);
    check("lu2_fwd_sel",   32'(fwd_rD1_sel), 32'd1);
    check("lu2_stall_cnt", stall_cnt, 32'd1);
    next_cycle();

    // ---- forwarding priority on rs2=3 ----
    clr_inputs();
    wr_ex = 3; rf_we_ex = 1; wr_mem = 3; rf_we_mem = 1; wr_wb = 3; rf_we_wb = 1;
    rs2_id = 3; rs2_used = 1; rs1_id = 3;
    @(negedge clk);
    check("fw_ex_en",  32'(fwd_rD2e), 32'd1);
    check("fw_ex_sel", 32'(fwd_rD2_sel), 32'd0);
    check("fw_rs1_unused", 32'(fwd_rD1e), 32'd0);
    next_cycle();
    rf_we_ex = 0;
    @(negedge clk);
    check("fw_mem_en",  32'(fwd_rD2e), 32'd1);
    check("fw_mem_sel", 32'(fwd_rD2_sel), 32'd1);
    next_cycle();
    rf_we_mem = 0;
    @(negedge clk);
    check("fw_wb_sel", 32'(fwd_rD2_sel), 32'd2);
    next_cycle();
    rs2_id = 0; wr_wb = 0; rf_we_ex = 1; wr_ex = 0;
    @(negedge clk);
    check("fw_x0_en",  32'(fwd_rD2e), 32'd0);
    check("fw_x0_sel", 32'(fwd_rD2_sel), 32'd0);
    next_cycle();

    // ---- load-use together with redirect ----
    clr_inputs();
    wr_ex = 7; rf_we_ex = 1; wd_sel_ex = 2'b01; rs2_id = 7; rs2_used = 1;
    redirect_ex = 1;
    @(negedge clk);
    check("rd_flush_if_id", 32'(flush_if_id), 32'd1);
    check("rd_flush_id_ex", 32'(flush_id_ex), 32'd1);
    check("rd_stall_pc",    32'(stall_pc), 32'd0);
    next_cycle();

    // ---- MUL/DIV with done after 5 BUSY cycles ----
    clr_inputs();
    md_req_ex = 1;
    @(negedge clk);
    check("md_idle_start", 32'(md_start), 32'd0);
    check("md_idle_stall", 32'(stall_pc), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      if (i == 3) redirect_ex = 1;
      else redirect_ex = 0;
      if (i == 5) md_done = 1;
      @(negedge clk);
      check($sformatf("md_busy%0d_stall_pc", i), 32'(stall_pc), 32'd1);
      check($sformatf("md_busy%0d_bubble", i), 32'(bubble_ex_mem), 32'd1);
      check($sformatf("md_busy%0d_start", i), 32'(md_start), (i == 1) ? 32'd1 : 32'd0);
      if (i == 3) check("md_busy_redirect_ignored", 32'(flush_if_id), 32'd0);
    end
    next_cycle();
    md_done = 0; redirect_ex = 0;   // md_req_ex still high in DONE
    @(negedge clk);
    check("md_done_stall_pc",    32'(stall_pc), 32'd0);
    check("md_done_stall_id_ex", 32'(stall_id_ex), 32'd0);
    check("md_done_stall_cnt",   stall_cnt, 32'd6);
    next_cycle();
    md_req_ex = 0;
    @(negedge clk);
    check("md_no_restart_start", 32'(md_start), 32'd0);
    next_cycle();
    @(negedge clk);
    check("md_no_restart_stall", 32'(stall_pc), 32'd0);
    check("md_no_timeout",       32'(md_timeout), 32'd0);
    next_cycle();

    // ---- MUL/DIV timeout: no done ----
    md_req_ex = 1;
    next_cycle();
    md_req_ex = 0;
    nstall = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (stall_pc !== 1'b1) break;
      nstall++;
      next_cycle();
    end
    check("to_busy_cycles", 32'(nstall), 32'd64);
    check("to_flag",        32'(md_timeout), 32'd1);
    check("to_stall_cnt",   stall_cnt, 32'd70);
    repeat (3) next_cycle();
    @(negedge clk);
    check("to_flag_sticky", 32'(md_timeout), 32'd1);
    check("to_idle_stall",  32'(stall_pc), 32'd0);
    next_cycle();

    // ---- reset asserted mid-BUSY ----
    md_req_ex = 1;
    next_cycle();
    md_req_ex = 0;
    next_cycle();
    @(negedge clk);
    check("rb_busy_before", 32'(stall_pc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_stall_pc",  32'(stall_pc), 32'd0);
    check("rb_bubble",    32'(bubble_ex_mem), 32'd0);
    check("rb_md_start",  32'(md_start), 32'd0);
    check("rb_timeout",   32'(md_timeout), 32'd0);
    check("rb_stall_cnt", stall_cnt, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rb_after_stall", 32'(stall_pc), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rb_after_start", 32'(md_start), 32'd0);
    check("rb_after_cnt",   stall_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RV32 pipeline.
- Computes ID-stage forwarding enables/selects consumed by the ID/EX pipeline register.
- Inserts load-use bubbles and applies branch/jump redirect flushes.
- Sequences the multi-cycle MUL/DIV unit in EX by freezing the front end until it completes.

Parameters:
- MD_TIMEOUT, 64, max cycles waited for md_done_i before forced release.
- WD_SEL_LOAD, 2'b01, wd_sel encoding marking a load (write-back from DRAM).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs1_id_i  in  5  ID source reg 1
- rs2_id_i  in  5  ID source reg 2
- rs1_used_id_i  in  1  ID instr reads rs1
- rs2_used_id_i  in  1  ID instr reads rs2
- wr_ex_i  in  5  EX dest reg
- rf_we_ex_i  in  1  EX writes RF
- wd_sel_ex_i  in  2  EX write-back source
- wr_mem_i  in  5  MEM dest reg
- rf_we_mem_i  in  1  MEM writes RF
- wr_wb_i  in  5  WB dest reg
- rf_we_wb_i  in  1  WB writes RF
- redirect_ex_i  in  1  taken branch or jump resolved in EX
- md_req_ex_i  in  1  EX holds a MUL/DIV instr (valid)
- md_done_i  in  1  MUL/DIV result ready (1-cycle pulse)
- stall_pc_o  out  1  hold PC
- stall_if_id_o  out  1  hold IF/ID
- flush_if_id_o  out  1  clear IF/ID
- flush_id_ex_o  out  1  clear ID/EX (bubble)
- stall_id_ex_o  out  1  hold ID/EX
- bubble_ex_mem_o  out  1  insert bubble into EX/MEM
- md_start_o  out  1  MUL/DIV start pulse
- fwd_rD1e_o  out  1  forward enable rD1
- fwd_rD1_sel_o  out  2  00 EX, 01 MEM, 10 WB
- fwd_rD2e_o  out  1  forward enable rD2
- fwd_rD2_sel_o  out  2  same encoding
- md_timeout_o  out  1  sticky: MUL/DIV timed out
- stall_cnt_o  out  32  cycles with stall_pc_o=1

Behaviour:
Forwarding (combinational):
- Per source: enable when used, rs!=0, and matched by a writing stage.
- Match priority: EX (rf_we_ex_i, wd_sel_ex_i!=WD_SEL_LOAD) > MEM > WB.
- A load in EX never forwards.
- x0 never forwarded; sel=00 when disabled.

Load-use (combinational):
- lu = rf_we_ex_i & wd_sel_ex_i==WD_SEL_LOAD & wr_ex_i!=0 & (rs1 match & used | rs2 match & used).
- lu -> stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1 for exactly that cycle.
- Next cycle the load is in MEM; forwarding sel=01 resolves the hazard.

Redirect:
- redirect_ex_i -> flush_if_id_o=1, flush_id_ex_o=1, stalls=0.
- Overrides lu in the same cycle.

MUL/DIV FSM, states MD_IDLE, MD_BUSY, MD_DONE; reset -> MD_IDLE:
- MD_IDLE:
  - md_req_ex_i=1 -> md_start_o=1 (1 cycle), go MD_BUSY, wait counter=0.
  - redirect_ex_i in the same cycle takes precedence for flushes.
- MD_BUSY:
  - stall_pc_o, stall_if_id_o, stall_id_ex_o, bubble_ex_mem_o all 1.
  - lu and redirect ignored.
  - Counter increments every cycle.
  - md_done_i -> MD_DONE.
  - Counter==MD_TIMEOUT-1 without done -> set md_timeout_o, go MD_DONE.
- MD_DONE:
  - One cycle, all stalls 0; EX/MEM captures the result.
  - -> MD_IDLE; md_req_ex_i is not re-sampled this cycle, preventing a restart on the same instr.
- md_done_i in MD_IDLE or MD_DONE is ignored.

General:
- stall_cnt_o increments (wraps at 2^32) each cycle stall_pc_o=1.
- md_timeout_o clears only on reset.
- Reset: all outputs 0, counters 0, FSM MD_IDLE; valid mid-MD_BUSY, no start re-issued.
- Flush/stall outputs combinational from FSM state and inputs; md_start_o registered-state derived, glitch-free.

Test Plan:
- lw x5 in EX, ID add uses rs1=5 -> 1 cycle stall_pc/stall_if_id/flush_id_ex=1; next cycle fwd_rD1e_o=1, sel=01.
- add x3 in EX, x3 in MEM and WB, ID reads rs2=3 -> fwd_rD2e_o=1, sel=00; EX rf_we=0 -> sel=01; rs2=0 -> enable 0.
- lu and redirect_ex_i together -> flush_if_id=1, flush_id_ex=1, stall_pc=0.
- md_req_ex_i, md_done_i after 5 cycles -> md_start_o one pulse; stalls high 5 cycles; MD_DONE stalls low; stall_cnt_o=5.
- md_req_ex_i, no done, MD_TIMEOUT=64 -> release after 64 BUSY cycles; md_timeout_o=1 held.
- rst_n low during MD_BUSY -> all outputs 0 immediately, FSM MD_IDLE, stall_cnt_o=0.
